// File: rtl/rv32im_wb_arbiter.sv
// Writeback arbiter for the RV32IM register file write port (ALU/LSU/MDU, round-robin)
// plus the pending-write scoreboard used by decode for RAW/WAW stalls.
module rv32im_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            alu_req_i,
  input  logic [AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_gnt_o,
  input  logic            lsu_req_i,
  input  logic [AW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_gnt_o,
  input  logic            mdu_req_i,
  input  logic [AW-1:0]   mdu_rd_i,
  input  logic [XLEN-1:0] mdu_data_i,
  output logic            mdu_gnt_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_rd_addr_o,
  output logic [XLEN-1:0] rf_val_rd_o,
  input  logic            issue_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic            issue_ready_o,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o
);

  logic [1:0]      ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0] sb_q, sb_d;
  logic            gnt_alu, gnt_lsu, gnt_mdu;

  // ptr names the highest-priority producer: 0=ALU, 1=LSU, 2=MDU
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    gnt_mdu = 1'b0;
    case (ptr_q)
      2'd1: begin
        if (lsu_req_i)      gnt_lsu = 1'b1;
        else if (mdu_req_i) gnt_mdu = 1'b1;
        else if (alu_req_i) gnt_alu = 1'b1;
      end
      2'd2: begin
        if (mdu_req_i)      gnt_mdu = 1'b1;
        else if (alu_req_i) gnt_alu = 1'b1;
        else if (lsu_req_i) gnt_lsu = 1'b1;
      end
      default: begin
        if (alu_req_i)      gnt_alu = 1'b1;
        else if (lsu_req_i) gnt_lsu = 1'b1;
        else if (mdu_req_i) gnt_mdu = 1'b1;
      end
    endcase
  end

  assign alu_gnt_o = gnt_alu;
  assign lsu_gnt_o = gnt_lsu;
  assign mdu_gnt_o = gnt_mdu;

  always_comb begin
    ptr_d     = ptr_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (gnt_alu) begin
      ptr_d     = 2'd1;
      rf_addr_d = alu_rd_i;
      rf_data_d = alu_data_i;
    end else if (gnt_lsu) begin
      ptr_d     = 2'd2;
      rf_addr_d = lsu_rd_i;
      rf_data_d = lsu_data_i;
    end else if (gnt_mdu) begin
      ptr_d     = 2'd0;
      rf_addr_d = mdu_rd_i;
      rf_data_d = mdu_data_i;
    end
    // x0 writes are accepted but never reach the register file
    if (gnt_alu || gnt_lsu || gnt_mdu) begin
      rf_we_d = (rf_addr_d != '0);
    end
  end

  // Clear applies first so a same-edge issue to the same register wins
  always_comb begin
    sb_d = sb_q;
    if (rf_we_q) begin
      sb_d[rf_addr_q] = 1'b0;
    end
    if (issue_i && issue_ready_o && (issue_rd_i != '0)) begin
      sb_d[issue_rd_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  assign issue_ready_o = ~sb_q[issue_rd_i];
  assign rs1_busy_o    = sb_q[rs1_addr_i];
  assign rs2_busy_o    = sb_q[rs2_addr_i];

  assign rf_we_o      = rf_we_q;
  assign rf_rd_addr_o = rf_addr_q;
  assign rf_val_rd_o  = rf_data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q     <= 2'd0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      sb_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      sb_q      <= sb_d;
    end
  end

endmodule

// File: doc/rv32im_wb_arbiter.md
# rv32im_wb_arbiter

Writeback arbiter and register scoreboard for the RV32IM core. It shares the register file's single write port between three result producers: the ALU, the load/store unit (LSU) and the multi-cycle multiply/divide unit (MDU). Each cycle it grants at most one producer using round-robin priority and drives a registered write into the register file. It also keeps a per-register pending-write scoreboard that decode uses for RAW/WAW hazard stalls.

## Interface
Parameters:
- XLEN, 32, data width of register values
- NREG, 32, number of architectural registers
- AW, 5, register address width (log2 NREG)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- alu_req_i / lsu_req_i / mdu_req_i  in  1 each  producer holds a valid result
- alu_rd_i / lsu_rd_i / mdu_rd_i  in  AW each  destination register
- alu_data_i / lsu_data_i / mdu_data_i  in  XLEN each  result value
- alu_gnt_o / lsu_gnt_o / mdu_gnt_o  out  1 each  result accepted this cycle (one-hot or zero)
- rf_we_o  out  1  register file write enable
- rf_rd_addr_o  out  AW  register file write address
- rf_val_rd_o  out  XLEN  register file write data
- issue_i  in  1  decode issues an instruction that writes issue_rd_i
- issue_rd_i  in  AW  destination of the issuing instruction
- issue_ready_o  out  1  issue permitted (no WAW conflict)
- rs1_addr_i / rs2_addr_i  in  AW each  decode source registers
- rs1_busy_o / rs2_busy_o  out  1 each  source has a pending write

## Operation
- **Request/grant handshake:**
  - A producer raises req with rd and data stable and holds all three until it sees gnt high at a clock edge.
  - gnt is combinational from the req inputs and the priority pointer.
  - Transfer occurs on an edge where req&gnt.
- **Round-robin arbitration:**
  - 2-bit pointer ptr ∈ {0=ALU, 1=LSU, 2=MDU} names the highest-priority producer.
  - Search order is ptr, ptr+1, ptr+2 (mod 3); the first requester found is granted.
  - After a grant to k, ptr ← (k+1) mod 3. With no grant, ptr holds.
- **Write register:**
  - On a transfer, rf_rd_addr_o/rf_val_rd_o load the granted rd/data.
  - rf_we_o ← 1 if rd≠0, else 0. A write to x0 is accepted (gnt asserted) but produces no write.
  - Without a transfer, rf_we_o ← 0 and addr/data hold.
- **Scoreboard:** NREG-bit vector sb; bit 0 is hardwired to 0.
  - Set: on an edge where issue_i & issue_ready_o & issue_rd_i≠0, sb[issue_rd_i] ← 1.
  - Clear: on an edge where rf_we_o=1, sb[rf_rd_addr_o] ← 0. This is the same edge on which the register file commits the write.
  - Set and clear of the same bit on the same edge: the set wins and the bit stays 1.
- **Hazard outputs:**
  - rsN_busy_o = sb[rsN_addr_i] (combinational); always 0 for x0.
  - issue_ready_o = ~sb[issue_rd_i]. It is always 1 for rd=0.
  - issue_i while issue_ready_o=0 has no effect.
- A producer writing an rd whose sb bit is 0 is legal: the write proceeds and sb is unchanged.

## Timing
- **Reset values (asynchronous):**
  - rf_we_o=0, rf_rd_addr_o=0, rf_val_rd_o=0
  - sb=all 0, ptr=0
  - All gnt outputs follow the requests combinationally.
- **Latency:** transfer at edge E → rf_we_o=1 during cycle E..E+1 → register file and scoreboard update at E+1. In the cycle after E+1, rsN_busy_o=0 and a regfile read returns the new value.
- **Throughput:** one write per cycle. Back-to-back grants to different producers are allowed on consecutive cycles.
- **Fairness:** a producer holding req is granted within 3 cycles.
- **Reset mid-operation:**
  - Pending registered writes are dropped (rf_we_o→0 immediately).
  - sb is cleared and ptr returns to 0.
  - Producers must re-present results after reset.

## Test plan
- **Reset:** assert rst_n_i=0 mid-cycle with rf_we_o=1 and sb[5]=1 → rf_we_o, rf_rd_addr_o, rf_val_rd_o and sb clear immediately, ptr=0.
- **Single write:** ALU req rd=3 data=0xDEADBEEF at edge E → alu_gnt_o=1 before E; rf_we_o=1, addr=3, data=0xDEADBEEF during the next cycle; then rf_we_o=0.
- **Round-robin:** all three request continuously from reset → grant order ALU, LSU, MDU, ALU; each gnt one-hot. Then only MDU requesting with ptr=0 → MDU granted and ptr becomes 0.
- **x0 write:** LSU req rd=0 data=0x1234 → lsu_gnt_o=1, rf_we_o stays 0, sb unchanged.
- **Scoreboard:**
  - issue rd=7 → rs1_addr_i=7 gives rs1_busy_o=1 next cycle, and issue_ready_o=0 for issue_rd_i=7.
  - MDU writes rd=7 → busy drops the cycle after rf_we_o=1.
- **Set/clear collision:** issue rd=9 on the same edge that rf_we_o=1 commits rd=9 → sb[9] remains 1 and rs2_busy_o=1 for rs2_addr_i=9.
